conv_sysarr_mac_pipe: RTL and testbench



---
 rtl/conv_sysarr_pkg.sv | 23 ++
 rtl/conv_sysarr_mac_mulcore.sv | 76 +++++++
 rtl/conv_sysarr_mac_pipe.sv | 125 ++++++++++++
 tb/tb_conv_sysarr_mac_pipe.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sysarr_pkg.sv
// rtl/conv_sysarr_pkg.sv - shared types and constants for the systolic-array MAC pipeline
package conv_sysarr_pkg;

  localparam int MUL_STAGES_MIN = 2;
  localparam int MUL_STAGES_MAX = 6;

  // Values of the SATURATE parameter
  localparam int SAT_WRAP  = 0;
  localparam int SAT_CLAMP = 1;

  typedef struct packed {
    logic valid;
    logic a_signed;
    logic b_signed;
    logic first;
    logic last;
  } mac_ctrl_t;

  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

endpackage

// File: rtl/conv_sysarr_mac_mulcore.sv
// rtl/conv_sysarr_mac_mulcore.sv - extended-operand multiplier with a MUL_STAGES-deep register chain
module conv_sysarr_mac_mulcore
  import conv_sysarr_pkg::*;
#(
  parameter int A_WIDTH    = 6,
  parameter int B_WIDTH    = 18,
  parameter int MUL_STAGES = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ce,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  input  mac_ctrl_t                  ctrl_in,
  output logic [A_WIDTH+B_WIDTH-1:0] p,
  output mac_ctrl_t                  ctrl_out
);

  localparam int P_WIDTH = prod_width(A_WIDTH, B_WIDTH);

  logic [A_WIDTH-1:0] a_d, a_q;
  logic [B_WIDTH-1:0] b_d, b_q;
  mac_ctrl_t          ctrl1_d, ctrl1_q;

  logic signed [A_WIDTH:0]   a_ext;
  logic signed [B_WIDTH:0]   b_ext;
  logic signed [P_WIDTH-1:0] a_full, b_full;

  logic [P_WIDTH-1:0] p_d    [2:MUL_STAGES];
  logic [P_WIDTH-1:0] p_q    [2:MUL_STAGES];
  mac_ctrl_t          ctrl_d [2:MUL_STAGES];
  mac_ctrl_t          ctrl_q [2:MUL_STAGES];

  always_comb begin
    a_d     = a;
    b_d     = b;
    ctrl1_d = ctrl_in;

    // One extra bit per operand makes a single signed multiply exact for all four mode mixes
    a_ext  = signed'({ctrl1_q.a_signed & a_q[A_WIDTH-1], a_q});
    b_ext  = signed'({ctrl1_q.b_signed & b_q[B_WIDTH-1], b_q});
    a_full = P_WIDTH'(a_ext);
    b_full = P_WIDTH'(b_ext);

    p_d[2]    = a_full * b_full;
    ctrl_d[2] = ctrl1_q;
    for (int k = 3; k <= MUL_STAGES; k++) begin
      p_d[k]    = p_q[k-1];
      ctrl_d[k] = ctrl_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      ctrl1_q <= '0;
      for (int k = 2; k <= MUL_STAGES; k++) begin
        p_q[k]    <= '0;
        ctrl_q[k] <= '0;
      end
    end else if (ce) begin
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl1_q <= ctrl1_d;
      for (int k = 2; k <= MUL_STAGES; k++) begin
        p_q[k]    <= p_d[k];
        ctrl_q[k] <= ctrl_d[k];
      end
    end
  end

  assign p        = p_q[MUL_STAGES];
  assign ctrl_out = ctrl_q[MUL_STAGES];

endmodule

// File: rtl/conv_sysarr_mac_pipe.sv
// rtl/conv_sysarr_mac_pipe.sv - pipelined MAC with framed accumulator, sticky overflow and optional saturation
module conv_sysarr_mac_pipe
  import conv_sysarr_pkg::*;
#(
  parameter int A_WIDTH    = 6,
  parameter int B_WIDTH    = 18,
  parameter int ACC_WIDTH  = 48,
  parameter int MUL_STAGES = 3,
  parameter int SATURATE   = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ce,
  input  logic                       in_valid,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  input  logic                       a_signed,
  input  logic                       b_signed,
  input  logic                       acc_first,
  input  logic                       acc_last,
  output logic [A_WIDTH+B_WIDTH-1:0] p,
  output logic                       p_valid,
  output logic [ACC_WIDTH-1:0]       acc,
  output logic                       acc_valid,
  output logic                       acc_ovf
);

  localparam int P_WIDTH = prod_width(A_WIDTH, B_WIDTH);

  if (MUL_STAGES < MUL_STAGES_MIN || MUL_STAGES > MUL_STAGES_MAX) begin : g_bad_stages
    $error("MUL_STAGES out of range");
  end
  if (ACC_WIDTH < P_WIDTH) begin : g_bad_acc
    $error("ACC_WIDTH must be at least the product width");
  end

  mac_ctrl_t          ctrl_in;
  mac_ctrl_t          ctrl_m;
  logic [P_WIDTH-1:0] p_m;

  assign ctrl_in = '{valid: in_valid, a_signed: a_signed, b_signed: b_signed,
                     first: acc_first, last: acc_last};

  conv_sysarr_mac_mulcore #(
    .A_WIDTH   (A_WIDTH),
    .B_WIDTH   (B_WIDTH),
    .MUL_STAGES(MUL_STAGES)
  ) u_mulcore (
    .clk     (clk),
    .reset   (reset),
    .ce      (ce),
    .a       (a),
    .b       (b),
    .ctrl_in (ctrl_in),
    .p       (p_m),
    .ctrl_out(ctrl_m)
  );

  logic [ACC_WIDTH-1:0] run_d, run_q;
  logic [ACC_WIDTH-1:0] acc_d, acc_q;
  logic                 acc_valid_d, acc_valid_q;
  logic                 acc_ovf_d, acc_ovf_q;

  logic                 sum_signed;
  logic [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH:0]   base_ext, p_ext, sum_ext;
  logic                 ovf;
  logic [ACC_WIDTH-1:0] sat_val, sum_new;

  always_comb begin
    sum_signed = ctrl_m.a_signed | ctrl_m.b_signed;
    base       = ctrl_m.first ? '0 : run_q;
    base_ext   = {sum_signed & base[ACC_WIDTH-1], base};
    p_ext      = sum_signed ? (ACC_WIDTH+1)'(signed'(p_m)) : (ACC_WIDTH+1)'(p_m);
    sum_ext    = base_ext + p_ext;

    // Signed overflow: the guard bit disagrees with the result sign; unsigned: carry out
    ovf = sum_signed ? (sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1]) : sum_ext[ACC_WIDTH];

    if (!sum_signed)
      sat_val = '1;
    else if (sum_ext[ACC_WIDTH])
      sat_val = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    else
      sat_val = {1'b0, {(ACC_WIDTH-1){1'b1}}};

    sum_new = (SATURATE == SAT_CLAMP && ovf) ? sat_val : sum_ext[ACC_WIDTH-1:0];

    run_d       = run_q;
    acc_d       = acc_q;
    acc_valid_d = 1'b0;
    acc_ovf_d   = acc_ovf_q;
    if (ctrl_m.valid) begin
      acc_ovf_d = (ctrl_m.first ? 1'b0 : acc_ovf_q) | ovf;
      if (ctrl_m.last) begin
        acc_d       = sum_new;
        acc_valid_d = 1'b1;
        run_d       = '0;
      end else begin
        run_d = sum_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q       <= '0;
      acc_q       <= '0;
      acc_valid_q <= 1'b0;
      acc_ovf_q   <= 1'b0;
    end else if (ce) begin
      run_q       <= run_d;
      acc_q       <= acc_d;
      acc_valid_q <= acc_valid_d;
      acc_ovf_q   <= acc_ovf_d;
    end
  end

  assign p         = p_m;
  assign p_valid   = ctrl_m.valid;
  assign acc       = acc_q;
  assign acc_valid = acc_valid_q;
  assign acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_conv_sysarr_mac_pipe.sv
// tb/tb_conv_sysarr_mac_pipe.sv - directed self-checking bench for conv_sysarr_mac_pipe
module tb_conv_sysarr_mac_pipe;

  logic        clk = 1'b0;
  logic        reset, ce, in_valid, a_signed, b_signed, acc_first, acc_last;
  logic [5:0]  a;
  logic [17:0] b;

  logic [23:0] p, p_s, p_w;
  logic        p_valid, p_valid_s, p_valid_w;
  logic [47:0] acc;
  logic [23:0] acc_s, acc_w;
  logic        acc_valid, acc_valid_s, acc_valid_w;
  logic        acc_ovf, acc_ovf_s, acc_ovf_w;

  int vectors     = 0;
  int miscompares = 0;
  int pulses;
  logic [47:0] acc_seen;

  always #5 clk = ~clk;

  conv_sysarr_mac_pipe dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
    .a_signed(a_signed), .b_signed(b_signed), .acc_first(acc_first), .acc_last(acc_last),
    .p(p), .p_valid(p_valid), .acc(acc), .acc_valid(acc_valid), .acc_ovf(acc_ovf)
  );

  conv_sysarr_mac_pipe #(.ACC_WIDTH(24), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
    .a_signed(a_signed), .b_signed(b_signed), .acc_first(acc_first), .acc_last(acc_last),
    .p(p_s), .p_valid(p_valid_s), .acc(acc_s), .acc_valid(acc_valid_s), .acc_ovf(acc_ovf_s)
  );

  conv_sysarr_mac_pipe #(.ACC_WIDTH(24), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
    .a_signed(a_signed), .b_signed(b_signed), .acc_first(acc_first), .acc_last(acc_last),
    .p(p_w), .p_valid(p_valid_w), .acc(acc_w), .acc_valid(acc_valid_w), .acc_ovf(acc_ovf_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic v, input logic [5:0] aa, input logic [17:0] bb,
                      input logic as, input logic bs, input logic f, input logic l);
    in_valid  = v;
    a         = aa;
    b         = bb;
    a_signed  = as;
    b_signed  = bs;
    acc_first = f;
    acc_last  = l;
  endtask

  task automatic idle();
    beat(1'b0, 6'd0, 18'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    ce    = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    chk("rst_p", p, 0);
    chk("rst_p_valid", p_valid, 0);
    chk("rst_acc", acc, 0);
    chk("rst_acc_valid", acc_valid, 0);
    chk("rst_acc_ovf", acc_ovf, 0);

    // Unsigned single-term frame at full scale
    beat(1, 6'd63, 18'd262143, 0, 0, 1, 1);
    tick();
    idle();
    tick();
    chk("u_p_valid_early", p_valid, 0);
    tick();
    chk("u_p", p, 24'd16515009);
    chk("u_p_valid", p_valid, 1);
    tick();
    chk("u_acc", acc, 48'd16515009);
    chk("u_acc_valid", acc_valid, 1);
    chk("u_acc_ovf", acc_ovf, 0);
    chk("u_p_valid_drop", p_valid, 0);
    tick();
    chk("u_acc_valid_pulse", acc_valid, 0);

    // Signed modes, back-to-back single-term frames
    beat(1, 6'h3F, 18'd5, 1, 0, 1, 1);
    tick();
    beat(1, 6'h20, 18'h20000, 1, 1, 1, 1);
    tick();
    idle();
    tick();
    chk("s_mixed_p", p, 24'hFFFFFB);
    chk("s_mixed_p_valid", p_valid, 1);
    tick();
    chk("s_both_p", p, 24'h400000);
    chk("s_mixed_acc", acc, 48'hFFFF_FFFF_FFFB);
    chk("s_mixed_acc_valid", acc_valid, 1);
    tick();
    chk("s_both_acc", acc, 48'd4194304);
    chk("s_both_acc_valid", acc_valid, 1);
    tick();
    chk("s_acc_valid_off", acc_valid, 0);

    // Four-beat frame with bubbles; bubbles carry junk data and flags
    beat(1, 6'd2, 18'd3, 0, 0, 1, 0);
    tick();
    beat(0, 6'd9, 18'd9, 0, 0, 0, 1);
    tick();
    beat(1, 6'd2, 18'd3, 0, 0, 0, 0);
    tick();
    beat(1, 6'd2, 18'd3, 0, 0, 0, 0);
    tick();
    beat(0, 6'd9, 18'd9, 0, 0, 1, 1);
    tick();
    beat(1, 6'd2, 18'd3, 0, 0, 0, 1);
    tick();
    idle();
    pulses   = 0;
    acc_seen = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (acc_valid) begin
        pulses++;
        acc_seen = acc;
      end
    end
    chk("frame_pulses", pulses, 1);
    chk("frame_acc", acc_seen, 48'd24);

    // Unsigned overflow of a 24-bit accumulator, clamped and wrapped
    beat(1, 6'd63, 18'd262143, 0, 0, 1, 0);
    tick();
    beat(1, 6'd63, 18'd262143, 0, 0, 0, 1);
    tick();
    idle();
    tick();
    tick();
    chk("ovf_not_yet", acc_ovf_s, 0);
    tick();
    chk("ovf_sat_acc", acc_s, 24'hFFFFFF);
    chk("ovf_sat_flag", acc_ovf_s, 1);
    chk("ovf_sat_valid", acc_valid_s, 1);
    chk("ovf_wrap_acc", acc_w, 24'hF7FF82);
    chk("ovf_wrap_flag", acc_ovf_w, 1);
    chk("ovf_wide_acc", acc, 48'd33030018);
    chk("ovf_wide_flag", acc_ovf, 0);

    beat(1, 6'd2, 18'd3, 0, 0, 1, 1);
    tick();
    idle();
    tick();
    tick();
    chk("ovf_sticky", acc_ovf_s, 1);
    tick();
    chk("ovf_clr_sat", acc_ovf_s, 0);
    chk("ovf_clr_wrap", acc_ovf_w, 0);
    chk("ovf_clr_sat_acc", acc_s, 24'd6);
    chk("ovf_clr_wrap_acc", acc_w, 24'd6);

    // Clock-enable freeze with a product at the output and junk at the input
    beat(1, 6'd7, 18'd5, 0, 0, 1, 1);
    tick();
    idle();
    tick();
    tick();
    chk("ce_p_before", p, 24'd35);
    ce = 1'b0;
    beat(1, 6'd1, 18'd1, 0, 0, 1, 1);
    repeat (5) tick();
    chk("ce_p_hold", p, 24'd35);
    chk("ce_p_valid_hold", p_valid, 1);
    chk("ce_acc_hold", acc, 48'd6);
    chk("ce_acc_valid_hold0", acc_valid, 0);
    ce = 1'b1;
    idle();
    tick();
    chk("ce_acc", acc, 48'd35);
    chk("ce_acc_valid", acc_valid, 1);
    chk("ce_p_valid_after", p_valid, 0);
    ce = 1'b0;
    tick();
    tick();
    chk("ce_acc_valid_hold1", acc_valid, 1);
    ce = 1'b1;
    tick();
    chk("ce_acc_valid_release", acc_valid, 0);

    // Reset mid-frame with beats in flight
    beat(1, 6'd4, 18'd4, 0, 0, 1, 0);
    tick();
    beat(1, 6'd4, 18'd4, 0, 0, 0, 0);
    tick();
    beat(1, 6'd4, 18'd4, 0, 0, 0, 1);
    tick();
    idle();
    chk("mrst_p_before", p, 24'd16);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_p", p, 0);
    chk("mrst_p_valid", p_valid, 0);
    chk("mrst_acc", acc, 0);
    chk("mrst_acc_valid", acc_valid, 0);
    chk("mrst_acc_ovf", acc_ovf, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (acc_valid) pulses++;
    end
    chk("mrst_no_residue", pulses, 0);

    beat(1, 6'd3, 18'd3, 0, 0, 1, 1);
    tick();
    idle();
    tick();
    tick();
    tick();
    chk("mrst_new_acc", acc, 48'd9);
    chk("mrst_new_valid", acc_valid, 1);

    // Last without first continues from the emptied running sum
    beat(1, 6'd5, 18'd1, 0, 0, 0, 1);
    tick();
    idle();
    tick();
    tick();
    tick();
    chk("nofirst_acc", acc, 48'd5);
    chk("nofirst_valid", acc_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
